i2s_tdm_rx: RTL
===============

Name: i2s_tdm_rx

Overview:
- Parametrised serial-audio receiver, successor to the fixed 2-channel 16-bit I2S receiver in the audio top level.
- Supports I2S (2-channel) and TDM (N-channel) framing, configurable sample and slot widths, and a ready/valid frame output with a one-entry holding register.
- Detects framing errors and overruns.
- Sits between the codec serial pins and the DSP, clocked directly by the codec bit clock.

Parameters:
- WIDTH, 16: captured sample bits per slot, MSB-first.
- SLOT_WIDTH, 16: bits per slot, >= WIDTH; trailing SLOT_WIDTH-WIDTH bits ignored.
- NUM_CHAN, 2: slots per frame, >= 1; must be 2 when TDM=0.
- TDM, 0: 0 = I2S framing (frame starts on ws falling edge); 1 = TDM framing (frame starts on ws rising edge; pulse width irrelevant).

Ports:
- sclk_i  in  1  bit clock; the only clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ws_i  in  1  word select / frame sync.
- sdata_i  in  1  serial data.
- samples_o  out  NUM_CHAN*WIDTH  held frame; slot k at [k*WIDTH +: WIDTH].
- valid_o  out  1  samples_o holds an unconsumed frame.
- ready_i  in  1  consumer accepts the frame when valid_o && ready_i at a rising edge.
- frame_err_o  out  1  one-cycle pulse on framing error.
- overrun_o  out  1  one-cycle pulse when a completed frame is dropped.
- err_led_o  out  1  sticky OR of all errors since reset.

Behaviour:
- Reset (rst_i high at edge): state=HUNT, bit_cnt=0, samples_o=0, valid_o=0, frame_err_o=0, overrun_o=0, err_led_o=0, ws_q<=ws_i. Loading ws_q from ws_i means no spurious edge on the first cycle after reset.
- Reset mid-frame discards the partial frame and any held frame.
- fs (frame start) = (TDM=0) ? (ws_q & ~ws_i) : (~ws_q & ws_i), evaluated at each edge; ws_q<=ws_i every edge.
- N = NUM_CHAN*SLOT_WIDTH. The MSB of slot 0 is sampled at the first edge after fs (one-bit delay).
- HUNT: sdata ignored. fs -> RECV with bit_cnt=0.
- RECV: the edge samples bit bit_cnt. Slot = bit_cnt / SLOT_WIDTH; offset = bit_cnt % SLOT_WIDTH. The bit is stored only if offset < WIDTH.
- RECV with bit_cnt < N-1 and no fs: bit_cnt++.
- RECV with bit_cnt == N-1: frame complete at this edge, including this bit.
  - With fs at the same edge (normal back-to-back framing): stay RECV, bit_cnt=0.
  - Without fs: go to HUNT, pulse frame_err_o (late sync). The completed frame is still delivered.
- RECV with fs and bit_cnt != N-1: early sync. Discard the partial frame, pulse frame_err_o, stay RECV with bit_cnt=0. The bit sampled at this edge is ignored.
- Frame delivery at the completion edge; latency is registered, visible one cycle after the last bit edge:
  - valid_o==0, or valid_o && ready_i: samples_o<=new frame, valid_o<=1.
  - valid_o && !ready_i: new frame dropped, samples_o unchanged, overrun_o pulse.
- No completion and valid_o && ready_i: valid_o<=0. samples_o holds its value.
- samples_o is stable whenever valid_o=1 until accepted.
- err_led_o is set by any frame_err_o or overrun_o pulse. It is cleared only by rst_i.
- bit_cnt width: $clog2(N). There is no wrap beyond N-1.

Decomposition:
- Package i2s_pkg:
  - state typedef enum {HUNT, RECV}.
  - Framing-mode localparams I2S_MODE=0, TDM_MODE=1.
  - Helper function for bit_cnt width.
- One sub-module, i2s_frame_sync: holds ws_q, produces fs, and contains the HUNT/RECV FSM plus bit_cnt. It outputs slot index, offset, bit_en and frame_done.
- The top block owns the shift/assembly register, the holding register and the handshake.

Test Plan:
- I2S, default params, ready_i=1: left=0xA5C3, right=0x1234 across 3 consecutive frames.
  - Required: samples_o=0x1234_A5C3, valid_o high one cycle after each right-LSB edge, no errors.
- TDM=1, NUM_CHAN=4, SLOT_WIDTH=32, WIDTH=24: slots 0x123456, 0xABCDEF, 0x000001, 0xFFFFFF, each padded with 8 junk bits of 0xFF.
  - Required: samples_o={0xFFFFFF,0x000001,0xABCDEF,0x123456}, junk not captured.
- Overrun: ready_i=0, send frames 0x1111_2222 then 0x3333_4444.
  - Required: samples_o stays 0x1111_2222, overrun_o pulses once at second completion, err_led_o=1.
  - Then ready_i=1: valid_o drops next cycle.
- Early sync: ws falls after 20 bits of a frame.
  - Required: frame_err_o one pulse, no valid_o for that frame.
  - The following full frame 0x0F0F_F0F0 is delivered correctly.
- Late sync: ws held constant after a full frame.
  - Required: frame delivered, frame_err_o pulse, state HUNT, further sdata ignored until the next ws falling edge.
- Reset asserted mid-frame with valid_o=1.
  - Required: all outputs 0 the next cycle.
  - No frame_err_o when ws is already low at reset release.
  - The first full frame after the next fs is delivered.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S/TDM serial-audio receiver.
package i2s_pkg;

    // Receiver framing state: waiting for a frame sync, or shifting in a frame.
    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    // Values for the TDM parameter.
    localparam int I2S_MODE = 0;
    localparam int TDM_MODE = 1;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_tdm_rx_if.sv
// Frame output stream of the receiver.
// Handshake: the master raises valid with samples stable and may not change
// samples while valid is high; the frame is consumed at a rising clock edge
// where valid && ready; ready may be driven regardless of valid.
interface i2s_tdm_rx_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] samples;
    logic              valid;
    logic              ready;

    modport master (output samples, output valid, input ready);
    modport slave  (input samples, input valid, output ready);
endinterface

// File: rtl/i2s_frame_sync.sv
// Frame synchroniser: detects frame starts on ws, runs the HUNT/RECV FSM and
// the bit counter, and tells the datapath where the current bit belongs.
module i2s_frame_sync
    import i2s_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SLOT_WIDTH = 16,
    parameter int NUM_CHAN   = 2,
    parameter int TDM        = I2S_MODE,
    localparam int N         = NUM_CHAN * SLOT_WIDTH,
    localparam int CW        = cnt_width(N),
    localparam int SLW       = cnt_width(NUM_CHAN),
    localparam int OFW       = cnt_width(SLOT_WIDTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ws,
    output state_t         state,
    output logic [SLW-1:0] slot,
    output logic [OFW-1:0] offset,
    output logic           bit_en,
    output logic           frame_done,
    output logic           err_now,
    output logic           frame_err
);

    logic          ws_q;
    logic [CW-1:0] bit_cnt;
    logic          fs;
    logic          last;

    // Frame start edge and position decode for the bit sampled at this edge.
    always_comb begin
        fs         = (TDM == I2S_MODE) ? (ws_q & ~ws) : (~ws_q & ws);
        last       = (bit_cnt == CW'(N - 1));
        slot       = SLW'(32'(bit_cnt) / SLOT_WIDTH);
        offset     = OFW'(32'(bit_cnt) % SLOT_WIDTH);
        frame_done = (state == RECV) && last;
        // An early sync discards the bit on that edge; at the last bit a sync is normal.
        bit_en     = (state == RECV) && (last || !fs) && (32'(offset) < WIDTH);
        err_now    = (state == RECV) && (last ? !fs : fs);
    end

    // HUNT/RECV FSM with bit counter; frame_err is a registered one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            ws_q      <= ws;
            frame_err <= 1'b0;
        end else begin
            ws_q      <= ws;
            frame_err <= 1'b0;
            case (state)
                HUNT: begin
                    if (fs) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                    end
                end
                RECV: begin
                    if (last) begin
                        bit_cnt <= '0;
                        if (!fs) begin
                            state     <= HUNT;
                            frame_err <= 1'b1;
                        end
                    end else if (fs) begin
                        bit_cnt   <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tdm_rx.sv
// Parametrised I2S/TDM receiver: assembles slots MSB-first into a frame and
// presents complete frames through a one-entry holding register.
module i2s_tdm_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SLOT_WIDTH = 16,
    parameter int NUM_CHAN   = 2,
    parameter int TDM        = I2S_MODE,
    localparam int FW        = NUM_CHAN * WIDTH,
    localparam int IW        = cnt_width(FW),
    localparam int SLW       = cnt_width(NUM_CHAN),
    localparam int OFW       = cnt_width(SLOT_WIDTH)
) (
    input  logic         sclk_i,
    input  logic         rst_i,
    input  logic         ws_i,
    input  logic         sdata_i,
    i2s_tdm_rx_if.master frame,
    output logic         frame_err_o,
    output logic         overrun_o,
    output logic         err_led_o,
    output state_t       state_o
);

    logic [SLW-1:0] slot;
    logic [OFW-1:0] offset;
    logic           bit_en;
    logic           frame_done;
    logic           err_now;
    logic [FW-1:0]  asm_q;
    logic [FW-1:0]  frame_next;
    logic [IW-1:0]  bit_idx;
    logic           drop;

    i2s_frame_sync #(
        .WIDTH      (WIDTH),
        .SLOT_WIDTH (SLOT_WIDTH),
        .NUM_CHAN   (NUM_CHAN),
        .TDM        (TDM)
    ) u_sync (
        .clk        (sclk_i),
        .rst        (rst_i),
        .ws         (ws_i),
        .state      (state_o),
        .slot       (slot),
        .offset     (offset),
        .bit_en     (bit_en),
        .frame_done (frame_done),
        .err_now    (err_now),
        .frame_err  (frame_err_o)
    );

    // Insert this edge's bit into the assembly image; MSB of a slot lands highest.
    always_comb begin
        frame_next = asm_q;
        bit_idx    = IW'(32'(slot) * WIDTH + (WIDTH - 1) - 32'(offset));
        if (bit_en) begin
            frame_next[bit_idx] = sdata_i;
        end
        drop = frame_done && frame.valid && !frame.ready;
    end

    // Assembly register, holding register, handshake and error reporting.
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            asm_q         <= '0;
            frame.samples <= '0;
            frame.valid   <= 1'b0;
            overrun_o     <= 1'b0;
            err_led_o     <= 1'b0;
        end else begin
            asm_q     <= frame_next;
            overrun_o <= drop;
            if (frame_done && !drop) begin
                frame.samples <= frame_next;
                frame.valid   <= 1'b1;
            end else if (!frame_done && frame.valid && frame.ready) begin
                frame.valid <= 1'b0;
            end
            if (err_now || drop) begin
                err_led_o <= 1'b1;
            end
        end
    end

endmodule
